pwm_frame_generator: RTL and testbench

- Upstream stage of the PWM-to-PPM converter.
- Accepts duty words over a valid/ready handshake, buffers them in a small FIFO, and emits one PWM frame per word.
- Produces PWMSIG plus the matching frame clock ClkSlowPWM, both synchronous to ClkFast.
- Outputs drive the converter's PWMSIG/ClkSlowPWM inputs directly; no extra glue logic.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_duty_fifo.sv | 59 +++++
 rtl/pwm_frame_generator.sv | 120 ++++++++++++
 tb/tb_pwm_frame_generator.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM frame generator and the downstream PWM-to-PPM converter.
package pwm_pkg;

    localparam int FRAME_LEN = 16;
    localparam int DUTY_W    = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_duty_fifo.sv
// Synchronous first-word-fall-through FIFO for duty words; the pointers carry one extra wrap bit.
module pwm_duty_fifo
    import pwm_pkg::*;
#(
    parameter int WIDTH = DUTY_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             empty,
    output logic             fullNext
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtrNext;
    logic [PTR_W-1:0] rdPtrNext;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             doPush;
    logic             doPop;

    // Equal addresses with differing wrap bits means the writer is a full lap ahead.
    assign empty    = (wrPtr == rdPtr);
    assign full     = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) &&
                      (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);
    assign fullNext = (wrPtrNext[ADDR_W] != rdPtrNext[ADDR_W]) &&
                      (wrPtrNext[ADDR_W-1:0] == rdPtrNext[ADDR_W-1:0]);

    assign doPush    = push && !full;
    assign doPop     = pop && !empty;
    assign wrPtrNext = wrPtr + PTR_W'(doPush);
    assign rdPtrNext = rdPtr + PTR_W'(doPop);
    assign popData   = mem[rdPtr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            wrPtr <= wrPtrNext;
            rdPtr <= rdPtrNext;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[ADDR_W-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/pwm_frame_generator.sv
// PWM frame generator: buffers duty words and emits one PWM frame plus its frame clock per word.
// Build option PWM_UNDERRUN_HOLD_EN: repeat the previous frame's duty on underrun instead of 0.
module pwm_frame_generator #(
    parameter int FRAME_LEN  = pwm_pkg::FRAME_LEN,
    parameter int DUTY_W     = pwm_pkg::DUTY_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              ClkFast,
    input  logic              RstN,
    input  logic [DUTY_W-1:0] DutyIn,
    input  logic              DutyValid,
    output logic              DutyReady,
    output logic              PWMSIG,
    output logic              ClkSlowPWM,
    output logic              Active,
    output logic              Underrun
);

    import pwm_pkg::*;

    localparam int FRAME_CNT_W = $clog2(FRAME_LEN);
    localparam logic [FRAME_CNT_W-1:0] HALF_FRAME = FRAME_CNT_W'(FRAME_LEN / 2);
    localparam logic [FRAME_CNT_W-1:0] MAX_DUTY   = FRAME_CNT_W'(FRAME_LEN - 1);

    function automatic logic [FRAME_CNT_W-1:0] clampDuty(input logic [DUTY_W-1:0] raw);
        logic [31:0] wide;
        wide = 32'(raw);
        if (wide > 32'(FRAME_LEN - 1)) begin
            return MAX_DUTY;
        end
        return FRAME_CNT_W'(raw);
    endfunction

    state_t                 state;
    logic [FRAME_CNT_W-1:0] frameCnt;
    logic [FRAME_CNT_W-1:0] activeDuty;
    logic [FRAME_CNT_W-1:0] dutyNow;
    logic [DUTY_W-1:0]      fifoHead;
    logic                   frameStart;
    logic                   fifoPush;
    logic                   fifoPop;
    logic                   fifoEmpty;
    logic                   fifoFullNext;

    assign fifoPush = DutyValid && DutyReady;

    pwm_duty_fifo #(
        .WIDTH (DUTY_W),
        .DEPTH (FIFO_DEPTH)
    ) dutyFifo (
        .clk      (ClkFast),
        .rstN     (RstN),
        .push     (fifoPush),
        .pushData (DutyIn),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .empty    (fifoEmpty),
        .fullNext (fifoFullNext)
    );

    // The frame-start duty comes straight from the FIFO head so the first output cycle already uses it.
    always_comb begin
        frameStart = (state == RUN) && (frameCnt == '0);
        fifoPop    = frameStart && !fifoEmpty;
        dutyNow    = activeDuty;
        if (frameStart) begin
            if (!fifoEmpty) begin
                dutyNow = clampDuty(fifoHead);
            end else begin
`ifdef PWM_UNDERRUN_HOLD_EN
                dutyNow = activeDuty;
`else
                dutyNow = '0;
`endif
            end
        end
    end

    always_ff @(posedge ClkFast) begin
        if (!RstN) begin
            state      <= IDLE;
            frameCnt   <= '0;
            PWMSIG     <= 1'b0;
            ClkSlowPWM <= 1'b0;
            Active     <= 1'b0;
            Underrun   <= 1'b0;
            DutyReady  <= 1'b1;
        end else begin
            DutyReady <= !fifoFullNext;
            Underrun  <= frameStart && fifoEmpty;
            case (state)
                IDLE: begin
                    frameCnt   <= '0;
                    PWMSIG     <= 1'b0;
                    ClkSlowPWM <= 1'b0;
                    if (!fifoEmpty) begin
                        state  <= RUN;
                        Active <= 1'b1;
                    end
                end
                RUN: begin
                    frameCnt   <= frameCnt + FRAME_CNT_W'(1);
                    PWMSIG     <= (frameCnt < dutyNow);
                    ClkSlowPWM <= (frameCnt < HALF_FRAME);
                    Active     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ClkFast) begin
        if (frameStart) begin
            activeDuty <= dutyNow;
        end
    end

endmodule

// File: tb/tb_pwm_frame_generator.sv
// Self-checking bench for pwm_frame_generator: vector table, directed frame sequences, random traffic vs. a queue model.
module tb_pwm_frame_generator;

    localparam int FRAME_LEN  = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int HIST       = 4096;

    logic       ClkFast   = 1'b0;
    logic       RstN      = 1'b0;
    logic [3:0] DutyIn    = 4'd0;
    logic       DutyValid = 1'b0;
    logic       DutyReady;
    logic       PWMSIG;
    logic       ClkSlowPWM;
    logic       Active;
    logic       Underrun;

    pwm_frame_generator #(
        .FRAME_LEN  (FRAME_LEN),
        .DUTY_W     (4),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .ClkFast    (ClkFast),
        .RstN       (RstN),
        .DutyIn     (DutyIn),
        .DutyValid  (DutyValid),
        .DutyReady  (DutyReady),
        .PWMSIG     (PWMSIG),
        .ClkSlowPWM (ClkSlowPWM),
        .Active     (Active),
        .Underrun   (Underrun)
    );

    always #5 ClkFast = ~ClkFast;

    typedef struct packed {
        logic       rstN;
        logic       valid;
        logic [3:0] duty;
        logic       pwm;
        logic       clk;
        logic       act;
        logic       und;
        logic       rdy;
    } vec_t;

    vec_t vecs[12];

    int checks  = 0;
    int errors  = 0;
    int edgeNum = 0;

    // Reference model: queue of accepted words, frames laid out arithmetically from the first frame edge.
    bit mRun   = 1'b0;
    int mFirst = 0;
    int mDuty  = 0;
    int mQ[$];
    bit mPwm = 1'b0, mClk = 1'b0, mAct = 1'b0, mUnd = 1'b0, mRdy = 1'b1;

    bit hPwm[HIST];
    bit hClk[HIST];
    bit hUnd[HIST];

    task automatic chk(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0b expected %0b", name, edgeNum, got, want);
        end
    endtask

    task automatic chkInt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic modelEdge();
        int pos;
        bit acc;
        if (!RstN) begin
            mQ.delete();
            mRun = 1'b0;
            mPwm = 1'b0; mClk = 1'b0; mAct = 1'b0; mUnd = 1'b0; mRdy = 1'b1;
            return;
        end
        acc  = DutyValid && mRdy;
        mUnd = 1'b0;
        if (!mRun) begin
            mPwm = 1'b0;
            mClk = 1'b0;
            if (mQ.size() > 0) begin
                mRun   = 1'b1;
                mFirst = edgeNum + 1;
            end
            mAct = mRun;
        end else begin
            pos = (edgeNum - mFirst) % FRAME_LEN;
            if (pos == 0) begin
                if (mQ.size() > 0) begin
                    mDuty = mQ.pop_front();
                end else begin
                    mUnd = 1'b1;
`ifndef PWM_UNDERRUN_HOLD_EN
                    mDuty = 0;
`endif
                end
            end
            mPwm = (pos < mDuty);
            mClk = (pos < FRAME_LEN / 2);
            mAct = 1'b1;
        end
        if (acc) mQ.push_back(int'(DutyIn));
        mRdy = (mQ.size() < FIFO_DEPTH);
    endtask

    task automatic tick();
        @(posedge ClkFast);
        modelEdge();
        #1;
        if (edgeNum < HIST) begin
            hPwm[edgeNum] = PWMSIG;
            hClk[edgeNum] = ClkSlowPWM;
            hUnd[edgeNum] = Underrun;
        end
        chk("PWMSIG", PWMSIG, mPwm);
        chk("ClkSlowPWM", ClkSlowPWM, mClk);
        chk("Active", Active, mAct);
        chk("Underrun", Underrun, mUnd);
        chk("DutyReady", DutyReady, mRdy);
        edgeNum++;
    endtask

    task automatic pushWord(input int val, output int accAt);
        bit rdyPre;
        accAt     = -1;
        DutyValid = 1'b1;
        DutyIn    = 4'(val);
        for (int g = 0; g < 64; g++) begin
            rdyPre = DutyReady;
            tick();
            if (rdyPre) begin
                accAt = edgeNum - 1;
                break;
            end
        end
        DutyValid = 1'b0;
        chk("push_accepted", accAt >= 0, 1'b1);
    endtask

    task automatic doReset();
        RstN      = 1'b0;
        DutyValid = 1'b0;
        tick();
        tick();
        RstN = 1'b1;
    endtask

    task automatic findRise(input int from, output int idx);
        idx = -1;
        for (int i = (from < 1 ? 1 : from); i < edgeNum && i < HIST; i++) begin
            if (hClk[i] && !hClk[i-1]) begin
                idx = i;
                break;
            end
        end
    endtask

    task automatic frameStats(input int base, output int pc, output int cc, output int uc);
        pc = 0; cc = 0; uc = 0;
        for (int j = 0; j < FRAME_LEN; j++) begin
            if (base >= 0 && base + j < edgeNum && base + j < HIST) begin
                pc += int'(hPwm[base + j]);
                cc += int'(hClk[base + j]);
                uc += int'(hUnd[base + j]);
            end
        end
    endtask

    initial begin
        int wordsC[8];
        int wordsD[5];
        int wordsE[4];
        int accD[5];
        int acc0, accX, rise, pc, cc, uc, fs, expHold;
        bit rdy4;

        vecs[0]  = '{1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wordsC = '{1, 2, 7, 8, 10, 12, 15, 3};
        wordsD = '{2, 4, 6, 8, 9};
        wordsE = '{9, 4, 6, 11};

        // Reset and a long idle stretch.
        doReset();
        repeat (100) tick();
        chk("idle_pwm", PWMSIG, 1'b0);
        chk("idle_clkslow", ClkSlowPWM, 1'b0);
        chk("idle_active", Active, 1'b0);
        chk("idle_ready", DutyReady, 1'b1);

        // Vector table: latency into a duty-10 frame, reset at frame position 5, FIFO left empty.
        for (int i = 0; i < 12; i++) begin
            RstN      = vecs[i].rstN;
            DutyValid = vecs[i].valid;
            DutyIn    = vecs[i].duty;
            tick();
            chk($sformatf("vec%0d_pwm", i), PWMSIG, vecs[i].pwm);
            chk($sformatf("vec%0d_clkslow", i), ClkSlowPWM, vecs[i].clk);
            chk($sformatf("vec%0d_active", i), Active, vecs[i].act);
            chk($sformatf("vec%0d_underrun", i), Underrun, vecs[i].und);
            chk($sformatf("vec%0d_ready", i), DutyReady, vecs[i].rdy);
        end
        DutyValid = 1'b0;
        RstN      = 1'b1;

        // Eight words back to back, honouring DutyReady.
        doReset();
        acc0 = -1;
        for (int w = 0; w < 8; w++) begin
            pushWord(wordsC[w], accX);
            if (w == 0) acc0 = accX;
        end
        repeat (150) tick();
        findRise(acc0, rise);
        chkInt("seq8_first_rise_latency", rise - acc0, 2);
        for (int k = 0; k < 8; k++) begin
            frameStats(rise + FRAME_LEN * k, pc, cc, uc);
            chkInt($sformatf("seq8_frame%0d_width", k), pc, wordsC[k]);
            chkInt($sformatf("seq8_frame%0d_clkhigh", k), cc, FRAME_LEN / 2);
            chk($sformatf("seq8_frame%0d_rise", k), hClk[rise + FRAME_LEN * k], 1'b1);
        end

        // Fill the FIFO just after a frame start; word 5 must wait for the next pop.
        fs = -1;
        for (int g = 0; g < 40 && fs < 0; g++) begin
            tick();
            if (mRun && ((edgeNum - 1 - mFirst) % FRAME_LEN == 0)) fs = edgeNum - 1;
        end
        chk("stall_sync_found", fs >= 0, 1'b1);
        rdy4 = 1'b1;
        for (int w = 0; w < 5; w++) begin
            if (w == 4) rdy4 = DutyReady;
            pushWord(wordsD[w], accD[w]);
        end
        chkInt("stall_word1_accept", accD[0], fs + 1);
        chkInt("stall_word4_accept", accD[3], fs + 4);
        chk("stall_ready_low_when_full", rdy4, 1'b0);
        chkInt("stall_word5_accept", accD[4], fs + FRAME_LEN + 1);
        repeat (20) tick();

        // Four words then silence: the fifth frame underruns.
        doReset();
        acc0 = -1;
        for (int w = 0; w < 4; w++) begin
            pushWord(wordsE[w], accX);
            if (w == 0) acc0 = accX;
        end
        repeat (100) tick();
        findRise(acc0, rise);
        chkInt("under_first_rise_latency", rise - acc0, 2);
        for (int k = 0; k < 4; k++) begin
            frameStats(rise + FRAME_LEN * k, pc, cc, uc);
            chkInt($sformatf("under_frame%0d_width", k), pc, wordsE[k]);
            chkInt($sformatf("under_frame%0d_pulses", k), uc, 0);
        end
        frameStats(rise + FRAME_LEN * 4, pc, cc, uc);
`ifdef PWM_UNDERRUN_HOLD_EN
        expHold = wordsE[3];
`else
        expHold = 0;
`endif
        chkInt("under_frame4_pulses", uc, 1);
        chk("under_frame4_pulse_at_start", hUnd[rise + FRAME_LEN * 4], 1'b1);
        chkInt("under_frame4_width", pc, expHold);

        // Duty extremes: 0 then 15.
        doReset();
        pushWord(0, acc0);
        pushWord(15, accX);
        repeat (45) tick();
        findRise(acc0, rise);
        frameStats(rise, pc, cc, uc);
        chkInt("duty0_width", pc, 0);
        frameStats(rise + FRAME_LEN, pc, cc, uc);
        chkInt("duty15_width", pc, 15);
        chk("duty15_last_high", hPwm[rise + FRAME_LEN + 14], 1'b1);
        chk("duty15_final_low", hPwm[rise + FRAME_LEN + 15], 1'b0);

        // Random traffic with occasional resets against the model.
        doReset();
        for (int n = 0; n < 800; n++) begin
            RstN      = ($urandom_range(0, 199) != 0);
            DutyValid = ($urandom_range(0, 99) < 35);
            DutyIn    = 4'($urandom_range(0, 15));
            tick();
        end
        DutyValid = 1'b0;
        RstN      = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
